cmn_fifo_drain: RTL and testbench

CMN_FIFO_DRAIN -- requirements
Module: cmn_fifo_drain

---
 rtl/cmn_fifo_drain.sv | 172 +++++++++++++++++
 tb/tb_cmn_fifo_drain.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmn_fifo_drain.sv
// ============================================================================
// cmn_fifo_drain
// ----------------------------------------------------------------------------
// Purpose
//   Drains an upstream show-ahead FIFO into a valid/ready output stream. The
//   upstream FIFO has a combinational read port: the head word is on
//   fifo_rdata in the same cycle that fifo_re is asserted, and there is no
//   read buffer. The read strobe therefore cannot wait for o_ready without
//   building a combinational path from downstream ready back into the FIFO.
//   Instead, a 2-entry ordered buffer (head buf0 + skid buf1) absorbs the
//   word that is already in flight when the consumer stalls. This keeps
//   fifo_re independent of o_ready while still sustaining one word per cycle.
//
//   The block also counts accepted output handshakes (o_beats). It can
//   discard all buffered words synchronously (flush).
//
// Parameters
//   DW  data width of the FIFO word and the output stream
//   CW  width of the accepted-beat counter (wraps modulo 2^CW)
//
// Ports
//   clk         in   rising-edge clock
//   rstn        in   asynchronous, active-low reset
//   fifo_empty  in   upstream FIFO empty flag
//   fifo_rdata  in   upstream FIFO head word, valid alongside fifo_re
//   fifo_re     out  pop strobe to the upstream FIFO (combinational)
//   flush       in   synchronous discard of all buffered words
//   o_valid     out  output stream valid (registered)
//   o_data      out  output stream data (registered, = head entry)
//   o_ready     in   downstream ready
//   o_count     out  number of words held internally (0..2)
//   o_beats     out  count of accepted output handshakes
// ============================================================================
module cmn_fifo_drain #(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          fifo_empty,
    input  logic [DW-1:0] fifo_rdata,
    output logic          fifo_re,
    input  logic          flush,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    input  logic          o_ready,
    output logic [1:0]    o_count,
    output logic [CW-1:0] o_beats
);

    // ------------------------------------------------------------------------
    // Occupancy state. The encoding equals the word count, so o_count is a
    // plain copy of the state register.
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_e;

    occ_e          state_q, state_d;
    logic [DW-1:0] buf0_q,  buf0_d;
    logic [DW-1:0] buf1_q,  buf1_d;
    logic          valid_q, valid_d;
    logic [CW-1:0] beats_q, beats_d;

    // run_q rises on the first clock edge after reset release. fifo_re is held
    // low until then. A word can never be popped in the partial cycle between
    // rstn deasserting and the first rising edge.
    logic          run_q;

    logic          push;
    logic          pop;

    // ------------------------------------------------------------------------
    // Read strobe. This path depends only on upstream status, flush and local
    // occupancy, never on o_ready. A full buffer is the only reason to stop
    // reading from a non-empty FIFO.
    // ------------------------------------------------------------------------
    always_comb begin
        fifo_re = rstn && run_q && !fifo_empty && !flush && (state_q != ST_FULL);
    end

    assign push = fifo_re;
    assign pop  = valid_q && o_ready;

    // ------------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;

        // Handshakes are counted even in a flush cycle. The consumer really
        // did take the head word on that edge.
        beats_d = beats_q + {{(CW-1){1'b0}}, pop};

        if (flush) begin
            // Only the occupancy is cleared. Stale data left in buf0/buf1 is
            // harmless because o_valid is low.
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        buf0_d  = fifo_rdata;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        // Head leaves as the new word arrives. The new word
                        // becomes the head, so no skid slot is needed.
                        buf0_d  = fifo_rdata;
                    end else if (push) begin
                        buf1_d  = fifo_rdata;
                        state_d = ST_FULL;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // fifo_re is low here, so the only event is a pop. The
                    // pop promotes the skid entry.
                    if (pop) begin
                        buf0_d  = buf1_q;
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end

        // o_valid comes from its own flop, so the stream has no decode
        // logic in front of it.
        valid_d = (state_d != ST_EMPTY);
    end

    // ------------------------------------------------------------------------
    // State registers. An asynchronous reset discards buffered words
    // immediately, even mid-transfer.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_EMPTY;
            buf0_q  <= '0;
            buf1_q  <= '0;
            valid_q <= 1'b0;
            beats_q <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf0_q  <= buf0_d;
            buf1_q  <= buf1_d;
            valid_q <= valid_d;
            beats_q <= beats_d;
            run_q   <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_valid = valid_q;
    assign o_data  = buf0_q;
    assign o_count = state_q;
    assign o_beats = beats_q;

endmodule

// File: tb/tb_cmn_fifo_drain.sv
// ============================================================================
// tb_cmn_fifo_drain
// ----------------------------------------------------------------------------
// Testbench for cmn_fifo_drain. The reference is a word queue for the upstream
// FIFO plus a word queue (at most two deep) for the words held by the block.
// A second instance with CW=4 shares all inputs and exercises beat-counter
// wrap.
// ============================================================================
module tb_cmn_fifo_drain;

    logic        clk = 1'b0;
    logic        rstn;
    logic        fifo_empty;
    logic [31:0] fifo_rdata;
    logic        flush;
    logic        o_ready;

    logic        fifo_re,  fifo_re4;
    logic        o_valid,  o_valid4;
    logic [31:0] o_data,   o_data4;
    logic [1:0]  o_count,  o_count4;
    logic [15:0] o_beats;
    logic [3:0]  o_beats4;

    always #5 clk = ~clk;

    cmn_fifo_drain #(.DW(32), .CW(16)) dut (
        .clk(clk), .rstn(rstn), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
        .fifo_re(fifo_re), .flush(flush), .o_valid(o_valid), .o_data(o_data),
        .o_ready(o_ready), .o_count(o_count), .o_beats(o_beats)
    );

    cmn_fifo_drain #(.DW(32), .CW(4)) dut4 (
        .clk(clk), .rstn(rstn), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
        .fifo_re(fifo_re4), .flush(flush), .o_valid(o_valid4), .o_data(o_data4),
        .o_ready(o_ready), .o_count(o_count4), .o_beats(o_beats4)
    );

    int total = 0;
    int bad   = 0;

    // Reference state
    logic [31:0] upq[$];        // upstream FIFO contents
    logic [31:0] held[$];       // words inside the block, head first
    logic [31:0] delivered[$];  // words observed leaving on the stream
    int unsigned mbeats;

    // Expected values for the current cycle, taken from the reference before
    // the cycle's edge.
    logic        exp_re, exp_valid;
    logic [31:0] exp_data;
    logic [1:0]  exp_count;
    logic [15:0] exp_beats;
    logic [3:0]  exp_beats4;

    // Observed values, sampled on the falling edge.
    logic        obs_re, obs_valid;
    logic [31:0] obs_data;
    logic [1:0]  obs_count;
    logic [15:0] obs_beats;
    logic [3:0]  obs_beats4;

    // One clock cycle. The task is entered 1 time unit after a rising edge.
    // It drives the inputs and records expected and observed values. It then
    // advances the reference across the next rising edge.
    task automatic step(input logic fl, input logic rdy);
        logic pop;
        flush      = fl;
        o_ready    = rdy;
        fifo_empty = (upq.size() == 0);
        if (fifo_empty) fifo_rdata = $urandom();
        else            fifo_rdata = upq[0];

        exp_re     = !fifo_empty && !fl && (held.size() < 2);
        exp_valid  = (held.size() != 0);
        if (exp_valid) exp_data = held[0];
        else           exp_data = '0;
        exp_count  = 2'(held.size());
        exp_beats  = 16'(mbeats);
        exp_beats4 = 4'(mbeats);

        @(negedge clk);
        obs_re     = fifo_re;
        obs_valid  = o_valid;
        obs_data   = o_data;
        obs_count  = o_count;
        obs_beats  = o_beats;
        obs_beats4 = o_beats4;
        if (obs_valid && rdy) delivered.push_back(obs_data);

        @(posedge clk);
        pop = exp_valid && rdy;
        if (pop) mbeats++;
        if (fl) begin
            held.delete();
        end else begin
            if (pop) void'(held.pop_front());
            if (exp_re) held.push_back(upq.pop_front());
        end
        #1;
    endtask

    task automatic apply_reset();
        rstn       = 1'b0;
        flush      = 1'b0;
        o_ready    = 1'b0;
        fifo_empty = 1'b1;
        fifo_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        upq.delete();
        held.delete();
        delivered.delete();
        mbeats = 0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        rstn       = 1'b0;
        flush      = 1'b0;
        o_ready    = 1'b1;
        fifo_empty = 1'b0;          // upstream claims data, reset must win
        fifo_rdata = 32'h5555_AAAA;
        repeat (3) @(posedge clk);
        #1;
        total++; if (fifo_re !== 1'b0)  begin bad++; $display("FAIL reset_re got=%b want=0", fifo_re); end
        total++; if (o_valid !== 1'b0)  begin bad++; $display("FAIL reset_valid got=%b want=0", o_valid); end
        total++; if (o_data !== 32'h0)  begin bad++; $display("FAIL reset_data got=%h want=0", o_data); end
        total++; if (o_count !== 2'd0)  begin bad++; $display("FAIL reset_count got=%0d want=0", o_count); end
        total++; if (o_beats !== 16'd0) begin bad++; $display("FAIL reset_beats got=%0d want=0", o_beats); end
        total++; if (o_beats4 !== 4'd0) begin bad++; $display("FAIL reset_beats4 got=%0d want=0", o_beats4); end
        @(negedge clk);
        rstn = 1'b1;
        #1;
        // Between reset release and the first rising edge, no pop is allowed.
        total++; if (fifo_re !== 1'b0)  begin bad++; $display("FAIL release_re got=%b want=0", fifo_re); end
        fifo_empty = 1'b1;
        @(posedge clk);
        #1;
        upq.delete(); held.delete(); delivered.delete(); mbeats = 0;
    endtask

    // Three words, consumer always ready: fixed timeline.
    task automatic test_basic_stream();
        logic        want_re[5]    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic        want_valid[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] want_data[5]  = '{32'h0, 32'hA, 32'hB, 32'hC, 32'h0};
        logic [15:0] want_beats[5] = '{16'd0, 16'd0, 16'd1, 16'd2, 16'd3};
        upq = '{32'hA, 32'hB, 32'hC};
        delivered.delete();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1);
            total++; if (obs_re !== want_re[i]) begin bad++; $display("FAIL basic_re cyc=%0d got=%b want=%b", i, obs_re, want_re[i]); end
            total++; if (obs_valid !== want_valid[i]) begin bad++; $display("FAIL basic_valid cyc=%0d got=%b want=%b", i, obs_valid, want_valid[i]); end
            if (want_valid[i]) begin
                total++; if (obs_data !== want_data[i]) begin bad++; $display("FAIL basic_data cyc=%0d got=%h want=%h", i, obs_data, want_data[i]); end
            end
            total++; if (obs_beats !== want_beats[i]) begin bad++; $display("FAIL basic_beats cyc=%0d got=%0d want=%0d", i, obs_beats, want_beats[i]); end
        end
        total++; if (delivered.size() != 3) begin bad++; $display("FAIL basic_delivered got=%0d words want=3", delivered.size()); end
    endtask

    // Four words with a stalled consumer, then release.
    task automatic test_backpressure();
        logic [31:0] w[4];
        int pulses;
        for (int i = 0; i < 4; i++) begin
            w[i] = $urandom();
            upq.push_back(w[i]);
        end
        delivered.delete();
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0);
            if (obs_re === 1'b1) pulses++;
            if (i >= 1) begin
                total++; if (obs_data !== w[0]) begin bad++; $display("FAIL bp_hold cyc=%0d got=%h want=%h", i, obs_data, w[0]); end
            end
        end
        total++; if (pulses != 2) begin bad++; $display("FAIL bp_pulses got=%0d want=2", pulses); end
        total++; if (obs_count !== 2'd2) begin bad++; $display("FAIL bp_count got=%0d want=2", obs_count); end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1);
            total++; if (obs_count !== exp_count) begin bad++; $display("FAIL bp_drain_count cyc=%0d got=%0d want=%0d", i, obs_count, exp_count); end
        end
        total++;
        if (delivered.size() != 4) begin
            bad++; $display("FAIL bp_words got=%0d words want=4", delivered.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (delivered[i] !== w[i]) begin
                    bad++; $display("FAIL bp_order idx=%0d got=%h want=%h", i, delivered[i], w[i]);
                    break;
                end
            end
        end
        total++; if (obs_beats !== exp_beats) begin bad++; $display("FAIL bp_beats got=%0d want=%0d", obs_beats, exp_beats); end
    endtask

    // Full buffer flushed while the consumer takes the head word.
    task automatic test_flush();
        logic [15:0] beats_before;
        upq = '{32'h11, 32'h22};
        repeat (3) step(1'b0, 1'b0);
        total++; if (obs_count !== 2'd2) begin bad++; $display("FAIL flush_pre_count got=%0d want=2", obs_count); end
        total++; if (obs_data !== 32'h11) begin bad++; $display("FAIL flush_pre_data got=%h want=11", obs_data); end
        upq.push_back(32'h33);      // upstream non-empty during the flush
        step(1'b1, 1'b1);
        beats_before = obs_beats;
        total++; if (obs_re !== 1'b0) begin bad++; $display("FAIL flush_re got=%b want=0", obs_re); end
        total++; if (obs_valid !== 1'b1) begin bad++; $display("FAIL flush_valid got=%b want=1", obs_valid); end
        step(1'b0, 1'b0);
        total++; if (obs_count !== 2'd0) begin bad++; $display("FAIL flush_count got=%0d want=0", obs_count); end
        total++; if (obs_valid !== 1'b0) begin bad++; $display("FAIL flush_post_valid got=%b want=0", obs_valid); end
        total++; if (obs_beats !== beats_before + 16'd1) begin bad++; $display("FAIL flush_beats got=%0d want=%0d", obs_beats, beats_before + 16'd1); end
        delivered.delete();
        repeat (3) step(1'b0, 1'b1);
        total++; if (delivered.size() != 1 || delivered[0] !== 32'h33) begin bad++; $display("FAIL flush_after got=%0d words want=1 word 33", delivered.size()); end
    endtask

    // 1000 random words, random upstream availability and consumer readiness.
    task automatic test_random();
        logic [31:0] sent[$];
        logic [15:0] beats_base;
        int cyc;
        sent.delete();
        delivered.delete();
        beats_base = 16'(mbeats);
        cyc = 0;
        while (delivered.size() < 1000 && cyc < 8000) begin
            if (sent.size() < 1000 && $urandom_range(0, 3) != 0) begin
                sent.push_back($urandom());
                upq.push_back(sent[sent.size()-1]);
            end
            step(1'b0, 1'($urandom_range(0, 2) != 0));
            total++; if (obs_re !== exp_re) begin bad++; $display("FAIL rand_re cyc=%0d got=%b want=%b", cyc, obs_re, exp_re); end
            total++; if (obs_valid !== exp_valid) begin bad++; $display("FAIL rand_valid cyc=%0d got=%b want=%b", cyc, obs_valid, exp_valid); end
            if (exp_valid) begin
                total++; if (obs_data !== exp_data) begin bad++; $display("FAIL rand_data cyc=%0d got=%h want=%h", cyc, obs_data, exp_data); end
            end
            total++; if (obs_count !== exp_count) begin bad++; $display("FAIL rand_count cyc=%0d got=%0d want=%0d", cyc, obs_count, exp_count); end
            total++; if (obs_beats !== exp_beats) begin bad++; $display("FAIL rand_beats cyc=%0d got=%0d want=%0d", cyc, obs_beats, exp_beats); end
            total++; if (obs_beats4 !== exp_beats4) begin bad++; $display("FAIL rand_beats4 cyc=%0d got=%0d want=%0d", cyc, obs_beats4, exp_beats4); end
            cyc++;
        end
        total++;
        if (delivered.size() != 1000) begin
            bad++; $display("FAIL rand_timeout delivered=%0d want=1000", delivered.size());
        end else begin
            for (int i = 0; i < 1000; i++) begin
                if (delivered[i] !== sent[i]) begin
                    bad++; $display("FAIL rand_order idx=%0d got=%h want=%h", i, delivered[i], sent[i]);
                    break;
                end
            end
        end
        step(1'b0, 1'b0);
        total++; if (obs_beats - beats_base !== 16'd1000) begin bad++; $display("FAIL rand_total_beats got=%0d want=1000", obs_beats - beats_base); end
    endtask

    // Reset asserted with two words held.
    task automatic test_reset_midflight();
        logic [31:0] w[4];
        for (int i = 0; i < 4; i++) begin
            w[i] = $urandom();
            upq.push_back(w[i]);
        end
        repeat (3) step(1'b0, 1'b0);
        total++; if (obs_count !== 2'd2) begin bad++; $display("FAIL rstmid_pre_count got=%0d want=2", obs_count); end
        #2;
        rstn = 1'b0;
        #1;   // no clock edge in between: the reset must act asynchronously
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b want=0", o_valid); end
        total++; if (o_data !== 32'h0) begin bad++; $display("FAIL rstmid_data got=%h want=0", o_data); end
        total++; if (o_beats !== 16'd0) begin bad++; $display("FAIL rstmid_beats got=%0d want=0", o_beats); end
        total++; if (o_count !== 2'd0) begin bad++; $display("FAIL rstmid_count got=%0d want=0", o_count); end
        total++; if (fifo_re !== 1'b0) begin bad++; $display("FAIL rstmid_re got=%b want=0", fifo_re); end
        held.delete();
        mbeats = 0;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        delivered.delete();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1);
            total++; if (obs_re !== exp_re) begin bad++; $display("FAIL rstmid_re_after cyc=%0d got=%b want=%b", i, obs_re, exp_re); end
            if (exp_valid) begin
                total++; if (obs_data !== exp_data) begin bad++; $display("FAIL rstmid_data_after cyc=%0d got=%h want=%h", i, obs_data, exp_data); end
            end
        end
        total++; if (delivered.size() != 2 || delivered[0] !== w[2] || delivered[1] !== w[3]) begin bad++; $display("FAIL rstmid_resume got=%0d words want=2 (%h %h)", delivered.size(), w[2], w[3]); end
    endtask

    // 17 handshakes from reset: the 4-bit counter wraps to 1.
    task automatic test_wrap();
        int guard;
        apply_reset();
        for (int i = 0; i < 17; i++) upq.push_back($urandom());
        guard = 0;
        while (mbeats < 17 && guard < 60) begin
            step(1'b0, 1'b1);
            guard++;
        end
        step(1'b0, 1'b0);
        total++; if (obs_beats4 !== 4'd1) begin bad++; $display("FAIL wrap_beats4 got=%0d want=1", obs_beats4); end
        total++; if (obs_beats !== 16'd17) begin bad++; $display("FAIL wrap_beats got=%0d want=17", obs_beats); end
    endtask

    initial begin
        rstn       = 1'b0;
        flush      = 1'b0;
        o_ready    = 1'b0;
        fifo_empty = 1'b1;
        fifo_rdata = '0;
        mbeats     = 0;
        test_reset();
        test_basic_stream();
        test_backpressure();
        test_flush();
        test_random();
        test_reset_midflight();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
